axi3_read_arbiter: RTL
======================

// Module: axi3_read_arbiter
// PURPOSE
//  Shares one AXI3 read master port (AR+R) among NUM_MASTERS requesters. Round-robin AR
//  arbitration through a one-entry output register; ARID carries the winner index; R beats
//  are routed back by RID. Per-requester outstanding limit; sticky error on stray R beats.
// PARAMETERS
//  NUM_MASTERS      4   requesters; must be <= 2**ID_WIDTH (elaboration error otherwise)
//  ID_WIDTH         2   m_arid/m_rid width
//  ADDR_WIDTH       32  address width
//  DATA_WIDTH       32  read data width
//  MAX_OUTSTANDING  4   max accepted-but-not-RLAST bursts per requester (>=1)
// PORTS
//  aclk        in   1                   clock, all logic on rising edge
//  aresetn     in   1                   reset, asynchronous, active-low
//  s_arvalid   in   NUM_MASTERS         per-requester AR valid
//  s_arready   out  NUM_MASTERS         per-requester AR accept (one-hot or zero)
//  s_araddr    in   NUM_MASTERS*ADDR_WIDTH  packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  s_arlen     in   NUM_MASTERS*4       AXI3 burst length-1
//  s_arsize    in   NUM_MASTERS*3       beat size
//  s_arburst   in   NUM_MASTERS*2       burst type
//  s_rvalid    out  NUM_MASTERS         routed R valid
//  s_rready    in   NUM_MASTERS         per-requester R ready
//  s_rdata     out  DATA_WIDTH          broadcast m_rdata
//  s_rresp     out  2                   broadcast m_rresp
//  s_rlast     out  1                   broadcast m_rlast
//  m_arvalid/m_arready/m_araddr/m_arlen/m_arsize/m_arburst/m_arid  AXI3 AR master, widths as above
//  m_rvalid in 1, m_rready out 1, m_rdata in DATA_WIDTH, m_rresp in 2, m_rlast in 1, m_rid in ID_WIDTH
//  err_rid     out  1                   sticky: R beat with RID>=NUM_MASTERS or zero outstanding
// BEHAVIOUR
//  Reset: m_arvalid=0, AR output fields=0, rr pointer=NUM_MASTERS-1, all counters=0, err_rid=0.
//  eligible[i] = s_arvalid[i] && cnt[i] < MAX_OUTSTANDING.
//  load = !m_arvalid || m_arready. When load and any eligible: winner = first eligible after
//   rr pointer (wrapping); s_arready[winner]=1 same cycle (comb., depends on m_arready);
//   next edge registers fields, m_arid=winner, m_arvalid=1, rr pointer=winner.
//  When load and none eligible: m_arvalid->0 next edge. Result: 1-cycle AR latency, 1 AR/cycle
//   sustained under m_arready=1.
//  m_arvalid high with m_arready low: all AR outputs stable, all s_arready=0.
//  cnt[i]++ on s_arvalid[i]&&s_arready[i]; cnt[m_rid]-- on m_rvalid&&m_rready&&m_rlast;
//   both same cycle, same i -> unchanged. cnt width clog2(MAX_OUTSTANDING+1).
//  R path combinational: s_rvalid[i]=m_rvalid&&(m_rid==i); m_rready=s_rready[m_rid].
//  Stray beat (m_rid>=NUM_MASTERS, or m_rid counter 0): m_rready=1 (drained), no s_rvalid,
//   no counter change, err_rid set at next edge, held until reset.
//  Interleaved RIDs permitted; routing purely per beat.
//  aresetn low mid-burst: outputs to reset values immediately; post-reset R beats are stray.
// STRUCTURE
//  Package axi3_arb_pkg: AXI3_LEN_W=4, AXI3_SIZE_W=3, AXI3_BURST_W=2, AXI3_RESP_W=2,
//   ar_req_t packed struct {addr,len,size,burst}, BURST_INCR/FIXED/WRAP constants.
//  Sub-module axi3_rr_arbiter: NUM_MASTERS-wide req vector + pointer -> one-hot grant + index.
// TESTING
//  1 Req0 addr 0x1000 len 3 INCR, m_arready=1 -> m_arvalid next cycle, m_arid=0; 4 RID=0 beats
//    reach s_rvalid[0] only; cnt[0] 1->0 on RLAST.
//  2 All four s_arvalid high, m_arready=1 -> grants 0,1,2,3 on consecutive cycles, ARIDs 0..3.
//  3 m_arready=0 for 5 cycles with req2 pending -> m_arvalid/fields stable, s_arready all 0;
//    on handshake req2 granted next.
//  4 Req1 issues 4 ARs, no R -> 5th held (s_arready[1]=0) while req2 granted; one RID=1 RLAST
//    -> 5th accepted next arbitration.
//  5 RID=2 and RID=0 beats interleaved, s_rready[0]=0 -> m_rready low on RID=0 beats only;
//    RID=3 beat with NUM_MASTERS=3 -> drained, err_rid=1 sticky.
//  6 aresetn low while m_arvalid=1, cnt[0]=2 -> m_arvalid=0 immediately, counters 0, err_rid 0.

Source files
------------

// File: rtl/axi3_read_arbiter_pkg.sv
// Shared AXI3 field widths, burst encodings and the registered AR request record
// used by the read arbiter.
package axi3_arb_pkg;

  localparam int AXI3_LEN_W   = 4;
  localparam int AXI3_SIZE_W  = 3;
  localparam int AXI3_BURST_W = 2;
  localparam int AXI3_RESP_W  = 2;
  localparam int AXI3_ADDR_W  = 32;

  localparam logic [AXI3_BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI3_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI3_BURST_W-1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [AXI3_ADDR_W-1:0]  addr;
    logic [AXI3_LEN_W-1:0]   len;
    logic [AXI3_SIZE_W-1:0]  size;
    logic [AXI3_BURST_W-1:0] burst;
  } ar_req_t;

endpackage

// File: rtl/axi3_read_arbiter_if.sv
// Bundle of the requester-side (s_*) and downstream master-side (m_*) AR/R signals.
// The arbiter connects through the slave modport; the environment through master.
interface axi3_read_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) ();
  import axi3_arb_pkg::*;

  logic [NUM_MASTERS-1:0]              s_arvalid;
  logic [NUM_MASTERS-1:0]              s_arready;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   s_araddr;
  logic [NUM_MASTERS*AXI3_LEN_W-1:0]   s_arlen;
  logic [NUM_MASTERS*AXI3_SIZE_W-1:0]  s_arsize;
  logic [NUM_MASTERS*AXI3_BURST_W-1:0] s_arburst;
  logic [NUM_MASTERS-1:0]              s_rvalid;
  logic [NUM_MASTERS-1:0]              s_rready;
  logic [DATA_WIDTH-1:0]               s_rdata;
  logic [AXI3_RESP_W-1:0]              s_rresp;
  logic                                s_rlast;

  logic                                m_arvalid;
  logic                                m_arready;
  logic [ADDR_WIDTH-1:0]               m_araddr;
  logic [AXI3_LEN_W-1:0]               m_arlen;
  logic [AXI3_SIZE_W-1:0]              m_arsize;
  logic [AXI3_BURST_W-1:0]             m_arburst;
  logic [ID_WIDTH-1:0]                 m_arid;
  logic                                m_rvalid;
  logic                                m_rready;
  logic [DATA_WIDTH-1:0]               m_rdata;
  logic [AXI3_RESP_W-1:0]              m_rresp;
  logic                                m_rlast;
  logic [ID_WIDTH-1:0]                 m_rid;

  modport slave (
    input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
    output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid
  );

  modport master (
    output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
    input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid
  );

endinterface

// File: rtl/axi3_read_arbiter_rr.sv
// Round-robin picker: grants the first requester strictly after the pointer,
// wrapping, as a one-hot vector plus its index.
module axi3_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   any_o
);

  // Scan positions ptr+1 .. ptr+NUM_MASTERS; the first hit wins.
  always_comb begin
    int  pos;
    logic hit;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      pos        = (int'(ptr_i) + k) % NUM_MASTERS;
      hit        = !any_o && req_i[pos];
      gnt_o[pos] = gnt_o[pos] | hit;
      idx_o      = hit ? IDX_W'(pos) : idx_o;
      any_o      = any_o | hit;
    end
  end

endmodule

// File: rtl/axi3_read_arbiter.sv
// Shares one AXI3 read master among NUM_MASTERS requesters: round-robin AR through a
// one-entry output register, RID-based R routing, per-requester outstanding limit.
module axi3_read_arbiter
  import axi3_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int ID_WIDTH        = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  axi3_read_arbiter_if.slave  bus,
  output logic                err_rid
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  if (NUM_MASTERS > (2 ** ID_WIDTH)) begin : g_bad_id_width
    $error("NUM_MASTERS exceeds the ID space of ID_WIDTH");
  end
  if (ADDR_WIDTH != AXI3_ADDR_W) begin : g_bad_addr_width
    $error("ADDR_WIDTH must match AXI3_ADDR_W");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max_outstanding
    $error("MAX_OUTSTANDING must be at least 1");
  end

  logic [NUM_MASTERS-1:0] eligible_s;
  logic [NUM_MASTERS-1:0] gnt_s;
  logic [NUM_MASTERS-1:0] s_arready_s;
  logic [NUM_MASTERS-1:0] s_rvalid_s;
  logic [NUM_MASTERS-1:0] inc_s;
  logic [NUM_MASTERS-1:0] dec_s;
  logic [ID_WIDTH-1:0]    win_idx_s;
  logic                   any_s;
  logic                   load_s;
  ar_req_t                win_req_s;
  logic                   drain_s;
  logic                   m_rready_s;
  logic                   rlast_hs_s;

  logic                   arvalid_q, arvalid_d;
  logic [ID_WIDTH-1:0]    arid_q, arid_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  ar_req_t                ar_q, ar_d;
  logic [CNT_W-1:0]       cnt_q [NUM_MASTERS];
  logic [CNT_W-1:0]       cnt_d [NUM_MASTERS];
  logic                   err_q, err_d;

  // A requester may compete only while it has room for another burst.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eligible_s[i] = bus.s_arvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  axi3_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (ID_WIDTH)
  ) u_rr (
    .req_i (eligible_s),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_s),
    .idx_o (win_idx_s),
    .any_o (any_s)
  );

  assign load_s      = !arvalid_q || bus.m_arready;
  assign s_arready_s = load_s ? gnt_s : '0;

  // Fields of the winning requester, picked out of the packed request buses.
  always_comb begin
    win_req_s.addr  = bus.s_araddr [int'(win_idx_s)*ADDR_WIDTH   +: ADDR_WIDTH];
    win_req_s.len   = bus.s_arlen  [int'(win_idx_s)*AXI3_LEN_W   +: AXI3_LEN_W];
    win_req_s.size  = bus.s_arsize [int'(win_idx_s)*AXI3_SIZE_W  +: AXI3_SIZE_W];
    win_req_s.burst = bus.s_arburst[int'(win_idx_s)*AXI3_BURST_W +: AXI3_BURST_W];
  end

  // Output register refills whenever it is empty or being consumed this cycle.
  always_comb begin
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    rr_ptr_d  = rr_ptr_q;
    ar_d      = ar_q;
    if (load_s) begin
      if (any_s) begin
        arvalid_d = 1'b1;
        arid_d    = win_idx_s;
        rr_ptr_d  = win_idx_s;
        ar_d      = win_req_s;
      end else begin
        arvalid_d = 1'b0;
      end
    end else begin
      arvalid_d = arvalid_q;
    end
  end

  // Beats with an unknown RID or for a requester with nothing outstanding are drained.
  always_comb begin
    drain_s    = 1'b1;
    m_rready_s = 1'b1;
    s_rvalid_s = '0;
    if (int'(bus.m_rid) < NUM_MASTERS) begin
      drain_s    = (cnt_q[bus.m_rid] == '0);
      m_rready_s = drain_s ? 1'b1 : bus.s_rready[bus.m_rid];
      s_rvalid_s[bus.m_rid] = bus.m_rvalid && !drain_s;
    end else begin
      drain_s    = 1'b1;
      m_rready_s = 1'b1;
    end
  end

  assign rlast_hs_s = bus.m_rvalid && m_rready_s && bus.m_rlast && !drain_s;

  // Outstanding counters: accept increments, final beat decrements, both cancel.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      inc_s[i] = bus.s_arvalid[i] && s_arready_s[i];
      dec_s[i] = rlast_hs_s && (int'(bus.m_rid) == i);
      case ({inc_s[i], dec_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  assign err_d = err_q | (bus.m_rvalid && drain_s);

  // State registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      rr_ptr_q  <= ID_WIDTH'(NUM_MASTERS - 1);
      ar_q      <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      rr_ptr_q  <= rr_ptr_d;
      ar_q      <= ar_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.s_arready = s_arready_s;
  assign bus.s_rvalid  = s_rvalid_s;
  assign bus.s_rdata   = bus.m_rdata;
  assign bus.s_rresp   = bus.m_rresp;
  assign bus.s_rlast   = bus.m_rlast;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_arid    = arid_q;
  assign bus.m_araddr  = ar_q.addr;
  assign bus.m_arlen   = ar_q.len;
  assign bus.m_arsize  = ar_q.size;
  assign bus.m_arburst = ar_q.burst;
  assign bus.m_rready  = m_rready_s;
  assign err_rid       = err_q;

endmodule
